// File: rtl/axi_mem_rd_arbiter_pkg.sv
// Shared types and constants for the two-master AXI read-channel arbiter.
package axi_mem_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    // Width-independent part of an AR request; the address is carried separately.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } ar_attr_t;

endpackage

// File: rtl/axi_mem_rd_arbiter_rr_grant2.sv
// Two-requester grant with priority pointer; ARB_ROUND_ROBIN_EN makes the pointer rotate.
module rr_grant2
    import axi_mem_rd_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_id,
    output logic [1:0] gnt
);

    logic ptr;

`ifdef ARB_ROUND_ROBIN_EN
    // After a burst completes, favour the master that was not just served.
    always_ff @(posedge clock) begin
        if (reset)
            ptr <= 1'b0;
        else if (done)
            ptr <= ~done_id;
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clock, reset, done, done_id};
    assign ptr       = 1'b0;
`endif

    assign gnt[0] = req[0] & (~req[1] | ~ptr);
    assign gnt[1] = req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/axi_mem_rd_arbiter.sv
// Two-master AXI4 read arbiter (icache = m0, dcache = m1) holding the grant for a whole burst.
// Define ARB_ROUND_ROBIN_EN for alternating priority; otherwise master 0 has fixed priority.
module axi_mem_rd_arbiter
    import axi_mem_rd_arbiter_pkg::*;
#(
    parameter int DW = 128,
    parameter int AW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          m0_ar_valid,
    output logic          m0_ar_ready,
    input  logic [AW-1:0] m0_ar_addr,
    input  logic [7:0]    m0_ar_len,
    input  logic [2:0]    m0_ar_size,
    input  logic [1:0]    m0_ar_burst,
    output logic          m0_r_valid,
    input  logic          m0_r_ready,
    output logic [DW-1:0] m0_r_data,
    output logic [1:0]    m0_r_rsp,
    output logic          m0_r_last,
    input  logic          m1_ar_valid,
    output logic          m1_ar_ready,
    input  logic [AW-1:0] m1_ar_addr,
    input  logic [7:0]    m1_ar_len,
    input  logic [2:0]    m1_ar_size,
    input  logic [1:0]    m1_ar_burst,
    output logic          m1_r_valid,
    input  logic          m1_r_ready,
    output logic [DW-1:0] m1_r_data,
    output logic [1:0]    m1_r_rsp,
    output logic          m1_r_last,
    output logic          s_ar_valid,
    input  logic          s_ar_ready,
    output logic [AW-1:0] s_ar_addr,
    output logic [7:0]    s_ar_len,
    output logic [2:0]    s_ar_size,
    output logic [1:0]    s_ar_burst,
    input  logic          s_r_valid,
    output logic          s_r_ready,
    input  logic [DW-1:0] s_r_data,
    input  logic [1:0]    s_r_rsp,
    input  logic          s_r_last,
    output logic          len_err,
    output logic          busy
);

    arb_state_t    state;
    logic          gnt_id;
    logic [7:0]    beat_cnt;
    logic [AW-1:0] ar_addr_q;
    ar_attr_t      ar_attr_q;
    logic [1:0]    gnt;
    logic          in_idle, in_data, ar_hs, r_hs, last_hs;

    assign in_idle = (state == ST_IDLE);
    assign in_data = (state == ST_DATA);

    rr_grant2 u_grant (
        .clock   (clock),
        .reset   (reset),
        .req     ({m1_ar_valid, m0_ar_valid}),
        .done    (last_hs),
        .done_id (gnt_id),
        .gnt     (gnt)
    );

    assign m0_ar_ready = in_idle & gnt[0];
    assign m1_ar_ready = in_idle & gnt[1];
    assign ar_hs       = (m0_ar_valid & m0_ar_ready) | (m1_ar_valid & m1_ar_ready);

    // R channel is a zero-latency pass-through steered by the registered grant.
    assign s_r_ready  = in_data & (gnt_id ? m1_r_ready : m0_r_ready);
    assign m0_r_valid = in_data & ~gnt_id & s_r_valid;
    assign m1_r_valid = in_data &  gnt_id & s_r_valid;
    assign m0_r_data  = s_r_data;
    assign m1_r_data  = s_r_data;
    assign m0_r_rsp   = s_r_rsp;
    assign m1_r_rsp   = s_r_rsp;
    assign m0_r_last  = s_r_last;
    assign m1_r_last  = s_r_last;
    assign r_hs       = s_r_valid & s_r_ready;
    assign last_hs    = r_hs & s_r_last;

    assign s_ar_addr  = ar_addr_q;
    assign s_ar_len   = ar_attr_q.len;
    assign s_ar_size  = ar_attr_q.size;
    assign s_ar_burst = ar_attr_q.burst;
    assign busy       = ~in_idle;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            s_ar_valid <= 1'b0;
            gnt_id     <= 1'b0;
            beat_cnt   <= 8'd0;
            len_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ar_hs) begin
                        gnt_id     <= gnt[1];
                        beat_cnt   <= 8'd0;
                        s_ar_valid <= 1'b1;
                        state      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (s_ar_ready) begin
                        s_ar_valid <= 1'b0;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (s_r_last) begin
                            if (beat_cnt != ar_attr_q.len)
                                len_err <= 1'b1;
                            state <= ST_IDLE;
                        end else if (beat_cnt == ar_attr_q.len) begin
                            len_err <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // AR payload registers carry no reset; they are qualified by s_ar_valid.
    always_ff @(posedge clock) begin
        if (in_idle && ar_hs) begin
            ar_addr_q       <= gnt[1] ? m1_ar_addr  : m0_ar_addr;
            ar_attr_q.len   <= gnt[1] ? m1_ar_len   : m0_ar_len;
            ar_attr_q.size  <= gnt[1] ? m1_ar_size  : m0_ar_size;
            ar_attr_q.burst <= gnt[1] ? m1_ar_burst : m0_ar_burst;
        end
    end

endmodule

// File: tb/tb_axi_mem_rd_arbiter.sv
// Randomized bench for axi_mem_rd_arbiter against a transaction-level reference model.
module tb_axi_mem_rd_arbiter;
    import axi_mem_rd_arbiter_pkg::*;

    localparam int DW = 128;
    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          m0_ar_valid, m0_ar_ready, m1_ar_valid, m1_ar_ready;
    logic [AW-1:0] m0_ar_addr, m1_ar_addr;
    logic [7:0]    m0_ar_len, m1_ar_len;
    logic [2:0]    m0_ar_size, m1_ar_size;
    logic [1:0]    m0_ar_burst, m1_ar_burst;
    logic          m0_r_valid, m0_r_ready, m0_r_last, m1_r_valid, m1_r_ready, m1_r_last;
    logic [DW-1:0] m0_r_data, m1_r_data;
    logic [1:0]    m0_r_rsp, m1_r_rsp;
    logic          s_ar_valid, s_ar_ready;
    logic [AW-1:0] s_ar_addr;
    logic [7:0]    s_ar_len;
    logic [2:0]    s_ar_size;
    logic [1:0]    s_ar_burst;
    logic          s_r_valid, s_r_ready, s_r_last;
    logic [DW-1:0] s_r_data;
    logic [1:0]    s_r_rsp;
    logic          len_err, busy;

    axi_mem_rd_arbiter #(.DW(DW), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr),
        .m0_ar_len(m0_ar_len), .m0_ar_size(m0_ar_size), .m0_ar_burst(m0_ar_burst),
        .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready), .m0_r_data(m0_r_data),
        .m0_r_rsp(m0_r_rsp), .m0_r_last(m0_r_last),
        .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr),
        .m1_ar_len(m1_ar_len), .m1_ar_size(m1_ar_size), .m1_ar_burst(m1_ar_burst),
        .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready), .m1_r_data(m1_r_data),
        .m1_r_rsp(m1_r_rsp), .m1_r_last(m1_r_last),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
        .s_r_rsp(s_r_rsp), .s_r_last(s_r_last),
        .len_err(len_err), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: sticky error flag and which master wins a tie.
    bit exp_err = 1'b0;
    bit exp_ptr = 1'b0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic ar_ready_of(input int m);
        return (m != 0) ? m1_ar_ready : m0_ar_ready;
    endfunction

    function automatic logic r_valid_of(input int m);
        return (m != 0) ? m1_r_valid : m0_r_valid;
    endfunction

    function automatic logic [DW-1:0] r_data_of(input int m);
        return (m != 0) ? m1_r_data : m0_r_data;
    endfunction

    function automatic logic [2:0] r_tail_of(input int m);
        return (m != 0) ? {m1_r_rsp, m1_r_last} : {m0_r_rsp, m0_r_last};
    endfunction

    task automatic set_ar(input int m, input logic v, input logic [AW-1:0] a, input logic [7:0] l,
                          input logic [2:0] sz, input logic [1:0] bt);
        if (m == 0) begin
            m0_ar_valid = v; m0_ar_addr = a; m0_ar_len = l; m0_ar_size = sz; m0_ar_burst = bt;
        end else begin
            m1_ar_valid = v; m1_ar_addr = a; m1_ar_len = l; m1_ar_size = sz; m1_ar_burst = bt;
        end
    endtask

    task automatic set_r_ready(input int m, input logic v);
        if (m == 0) m0_r_ready = v; else m1_r_ready = v;
    endtask

    // One arbitrated burst. nb = beats the slave returns (last on beat nb); abort_at > 0 resets
    // the arbiter after that many beats.
    task automatic do_burst(input bit both, input int req_m, input logic [AW-1:0] a0,
                            input int len, input int nb, input int stall, input int abort_at);
        int            w, cyc, tries;
        logic [AW-1:0] addr;
        logic [2:0]    sz;
        logic [1:0]    bt;
        logic          rdy;

        w = both ? int'(exp_ptr) : req_m;
        for (int m = 0; m < 2; m++) begin
            addr = (m == 0 && a0 != 0) ? a0 : ($urandom & 32'hFFFF_FFF0);
            sz   = 3'($urandom_range(0, 4));
            bt   = (a0 != 0) ? BURST_INCR : 2'($urandom_range(0, 2));
            if (both || m == req_m)
                set_ar(m, 1'b1, addr, 8'(len), sz, bt);
            else
                set_ar(m, 1'b0, addr, 8'(len), sz, bt);
        end
        addr = (w == 0) ? m0_ar_addr : m1_ar_addr;
        sz   = (w == 0) ? m0_ar_size : m1_ar_size;
        bt   = (w == 0) ? m0_ar_burst : m1_ar_burst;

        cyc = 0;
        #1;
        while (!ar_ready_of(w) && cyc < 20) begin
            @(negedge clock); #1;
            cyc++;
        end
        check_val("ar_ready_winner", ar_ready_of(w), 1'b1);
        check_val("ar_ready_loser", ar_ready_of(1 - w), 1'b0);
        check_val("s_ar_valid_before", s_ar_valid, 1'b0);

        @(negedge clock);
        set_ar(w, 1'b0, addr, 8'(len), sz, bt);
        #1;
        check_val("s_ar_valid_n1", s_ar_valid, 1'b1);
        check_val("busy_addr", busy, 1'b1);
        for (int i = 0; i <= stall; i++) begin
            s_r_valid = (i < stall) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            check_val("s_ar_fields", {s_ar_valid, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst},
                      {1'b1, addr, 8'(len), sz, bt});
            check_val("s_r_ready_addr", s_r_ready, 1'b0);
            check_val("ar_ready_addr", {m1_ar_ready, m0_ar_ready}, 2'b00);
            if (i < stall) begin
                @(negedge clock); #1;
            end
        end
        s_ar_ready = 1'b1;
        @(negedge clock);
        s_ar_ready = 1'b0;
        #1;
        check_val("s_ar_single", s_ar_valid, 1'b0);

        for (int k = 0; k < nb; k++) begin
            s_r_valid = 1'b1;
            s_r_data  = {$urandom, $urandom, $urandom, $urandom};
            s_r_rsp   = 2'($urandom_range(0, 3));
            s_r_last  = (k == nb - 1);
            tries     = 0;
            do begin
                rdy = (tries >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                set_r_ready(w, rdy);
                set_r_ready(1 - w, 1'($urandom_range(0, 1)));
                #1;
                check_val("r_valid_winner", r_valid_of(w), 1'b1);
                check_val("r_valid_loser", r_valid_of(1 - w), 1'b0);
                check_val("r_data", r_data_of(w), s_r_data);
                check_val("r_rsp_last", r_tail_of(w), {s_r_rsp, s_r_last});
                check_val("s_r_ready_mirror", s_r_ready, rdy);
                @(negedge clock);
                tries++;
            end while (!rdy);
            if (s_r_last && k != len) exp_err = 1'b1;
            if (!s_r_last && k == len) exp_err = 1'b1;

            if (abort_at > 0 && k + 1 == abort_at) begin
                reset       = 1'b1;
                m0_ar_valid = 1'b0;
                m1_ar_valid = 1'b0;
                @(negedge clock); #1;
                check_val("rst_busy", busy, 1'b0);
                check_val("rst_valids", {s_ar_valid, m0_r_valid, m1_r_valid}, 3'b000);
                check_val("rst_readies", {s_r_ready, m0_ar_ready, m1_ar_ready}, 3'b000);
                check_val("rst_len_err", len_err, 1'b0);
                exp_err   = 1'b0;
                exp_ptr   = 1'b0;
                reset     = 1'b0;
                s_r_valid = 1'b0;
                s_r_last  = 1'b0;
                return;
            end
        end
        s_r_valid  = 1'b0;
        s_r_last   = 1'b0;
        m0_r_ready = 1'b0;
        m1_r_ready = 1'b0;
        #1;
        check_val("busy_after_last", busy, 1'b0);
        check_val("len_err", len_err, exp_err);
`ifdef ARB_ROUND_ROBIN_EN
        exp_ptr = (w == 0);
`endif
    endtask

    initial begin
        int len;
        reset = 1'b1;
        set_ar(0, 1'b0, '0, '0, '0, '0);
        set_ar(1, 1'b0, '0, '0, '0, '0);
        m0_r_ready = 1'b0; m1_r_ready = 1'b0;
        s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_data = '0; s_r_rsp = RESP_OKAY; s_r_last = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check_val("reset_outputs", {s_ar_valid, s_r_ready, m0_r_valid, m1_r_valid, busy, len_err},
                  6'b0);
        reset = 1'b0;
        @(negedge clock);

        // Stray slave beat while idle must be held off.
        s_r_valid = 1'b1; s_r_last = 1'b1; s_r_rsp = RESP_SLVERR;
        #1;
        check_val("stray_r", {s_r_ready, m0_r_valid, m1_r_valid, busy}, 4'b0);
        @(negedge clock);
        s_r_valid = 1'b0; s_r_last = 1'b0;

        do_burst(1'b0, 0, 32'h8000_0000, 3, 4, 0, 0);
        do_burst(1'b0, 1, '0, 2, 3, 1, 0);
        for (int i = 0; i < 4; i++)
            do_burst(1'b1, 0, '0, 0, 1, 0, 0);
        do_burst(1'b0, 0, '0, 5, 6, 5, 0);
        do_burst(1'b0, 1, '0, 1, 1, 0, 0);
        do_burst(1'b1, 0, '0, 0, 3, 2, 0);
        for (int i = 0; i < 12; i++) begin
            len = $urandom_range(0, 7);
            do_burst(1'($urandom_range(0, 1)), $urandom_range(0, 1), '0, len,
                     ($urandom_range(0, 5) == 0) ? $urandom_range(1, 9) : len + 1,
                     $urandom_range(0, 3), 0);
        end
        do_burst(1'b0, 0, '0, 7, 8, 0, 2);
        do_burst(1'b1, 0, '0, 2, 3, 1, 0);
        do_burst(1'b1, 0, '0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mem_rd_arbiter.md
Name: axi_mem_rd_arbiter

Overview:
Two-master AXI4 read-channel arbiter that shares the 128-bit memory read channel (AR/R) between the instruction-cache refill and data-cache refill engines. It grants one master at a time and holds the grant for the whole burst until the last beat. It registers the granted AR and checks the returned burst length. It sits between the core's cache refill units and the memory port that feeds the external AXI SRAM slave.

Parameters:
DW, 128, R data width in bits
AW, 32, address width in bits

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_ar_valid / m0_ar_ready  in / out  1 / 1  master 0 (icache) AR handshake
m0_ar_addr  in  AW  master 0 address
m0_ar_len  in  8  master 0 burst length minus 1
m0_ar_size  in  3  master 0 beat size
m0_ar_burst  in  2  master 0 burst type
m0_r_valid / m0_r_ready  out / in  1 / 1  master 0 R handshake
m0_r_data  out  DW  master 0 read data
m0_r_rsp  out  2  master 0 read response
m0_r_last  out  1  master 0 last beat
m1_*: identical set of ports for master 1 (dcache)
s_ar_valid / s_ar_ready  out / in  1 / 1  slave-side AR handshake
s_ar_addr / s_ar_len / s_ar_size / s_ar_burst  out  AW/8/3/2  slave-side AR fields
s_r_valid / s_r_ready  in / out  1 / 1  slave-side R handshake
s_r_data / s_r_rsp / s_r_last  in  DW/2/1  slave-side R fields
len_err  out  1  sticky flag: RLAST position did not match the granted len
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock `clock`; reset `reset` is synchronous and active-high.
- Reset values: state=IDLE; s_ar_valid=0; all m*_ar_ready=0; all m*_r_valid=0; s_r_ready=0; len_err=0; beat counter=0; priority pointer=0 (master 0 favoured).
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - m*_ar_ready is combinational and high only for the winner.
  - Winner = the only requester if one requests; the priority-pointer master if both request.
  - On the winner's handshake: latch its AR fields, grant id and len, clear the beat counter, go to ADDR.
  - Latency: m_ar handshake in cycle N -> s_ar_valid high in cycle N+1.
- ADDR:
  - s_ar_valid=1 with the registered fields, held stable until s_ar_ready.
  - All m*_ar_ready=0.
  - On s_ar handshake -> DATA.
- DATA:
  - Granted master: m_r_valid = s_r_valid, its data/rsp/last = slave fields, and s_r_ready = its m_r_ready (combinational, zero latency).
  - Non-granted master: r_valid=0.
  - Each R handshake increments the 8-bit beat counter.
  - On an R handshake with s_r_last=1: if counter != granted len, set len_err. Then go to IDLE and, if round-robin is enabled, point priority at the other master.
  - If counter == len and s_r_last=0: set len_err and keep forwarding until last.
- In IDLE and ADDR, s_r_ready=0; stray slave R beats are back-pressured, not dropped.
- Back-to-back transactions: the earliest next m_ar handshake is the cycle after the last-beat handshake (IDLE spends at least 1 cycle).
- A non-granted master may hold ar_valid indefinitely; it is served after the current burst completes.
- len_err clears only on reset.
- Reset mid-burst: FSM returns to IDLE next edge and outputs take reset values. The abandoned burst is not resumed; the slave must be reset together with the arbiter.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: the priority pointer toggles to the other master after every completed burst. Under continuous contention, grants alternate 0,1,0,1.
- Undefined: the pointer is tied to 0, giving fixed priority to master 0 (icache). Master 1 is granted only when m0_ar_valid=0 in IDLE.

Decomposition:
- Shared package: FSM state encoding (IDLE/ADDR/DATA), AXI burst-type constants (FIXED=0, INCR=1, WRAP=2), AXI response constants (OKAY=0, SLVERR=2), and the AR-field bundle typedef.
- One natural sub-module, `rr_grant2`: 2-requester grant logic with priority pointer and the ARB_ROUND_ROBIN_EN switch. The arbiter instantiates it in IDLE.

Test Plan:
- Single request: m0 requests addr 0x80000000, len=3, INCR; slave returns 4 beats -> exactly one s_ar with matching fields one cycle after the m0 handshake; m0 receives 4 beats with last on beat 4; m1_r_valid stays 0; len_err=0.
- Contention: m0 and m1 both hold ar_valid with len=0.
  - With ARB_ROUND_ROBIN_EN: grant order 0,1,0,1 across 4 bursts.
  - Without it: master 1 is never granted while m0 keeps requesting.
- Back-pressure: s_ar_ready low for 5 cycles -> s_ar_valid and fields stable all 5 cycles. m0_r_ready toggled every cycle -> s_r_ready mirrors it and no beat is lost or duplicated.
- Length errors:
  - len=1 but slave asserts last on beat 1 -> len_err=1 and FSM back to IDLE.
  - len=0 but slave's first beat has last=0 -> len_err=1, forwarding continues until last.
- Stray R: slave asserts s_r_valid while in IDLE -> s_r_ready=0 and both m*_r_valid=0.
- Reset mid-burst: assert reset after beat 2 of a len=7 burst -> next edge state=IDLE, all valids/readies 0, len_err=0, busy=0.
